// File: rtl/axi_master_arbiter.sv
// rtl/axi_master_arbiter.sv - two-requester round-robin sequencer in front of AXI_memory_master
// One single-beat transaction at a time; completion is observed on the monitored AXI channels.
module axi_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    done0,
  output logic                    done1,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              resp_o,
  output logic                    err_o,
  output logic                    start_write,
  output logic                    start_read,
  output logic [ID_WIDTH-1:0]     write_id,
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [ID_WIDTH-1:0]     read_id,
  output logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [7:0]              write_len,
  output logic [7:0]              read_len,
  output logic [2:0]              write_size,
  output logic [2:0]              read_size,
  output logic [1:0]              write_burst,
  output logic [1:0]              read_burst,
  output logic [DATA_WIDTH/8-1:0] write_strb,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic                    arvalid,
  input  logic                    arready,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic [1:0]              bresp,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic                    rlast,
  input  logic [1:0]              rresp,
  input  logic [DATA_WIDTH-1:0]   rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  last_q, last_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  start_write_q, start_write_d;
  logic                  start_read_q, start_read_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic       addr_hs;
  logic       cpl_wr;
  logic       cpl_rd;
  logic [1:0] cpl_resp;
  logic       winner;
  logic       win_we;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    sel_d         = sel_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    start_write_d = start_write_q;
    start_read_d  = start_read_q;
    gnt0_d        = gnt0_q;
    gnt1_d        = gnt1_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    rdata_d       = rdata_q;
    resp_d        = resp_q;
    err_d         = err_q;
    cnt_d         = cnt_q;

    // Only the channel of the transaction in flight can complete it.
    addr_hs  = we_q ? (awvalid && awready) : (arvalid && arready);
    cpl_wr   = we_q && bvalid && bready;
    cpl_rd   = !we_q && rvalid && rready && rlast;
    cpl_resp = cpl_wr ? bresp : rresp;
    winner   = (req0 && req1) ? ~last_q : req1;
    win_we   = winner ? we1 : we0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          sel_d         = winner;
          last_d        = winner;
          we_d          = win_we;
          addr_d        = winner ? addr1 : addr0;
          wdata_d       = winner ? wdata1 : wdata0;
          start_write_d = win_we;
          start_read_d  = !win_we;
          gnt0_d        = !winner;
          gnt1_d        = winner;
          cnt_d         = '0;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (cpl_wr || cpl_rd) begin
          resp_d        = cpl_resp;
          err_d         = |cpl_resp;
          if (cpl_rd) rdata_d = rdata;
          start_write_d = 1'b0;
          start_read_d  = 1'b0;
          done0_d       = !sel_q;
          done1_d       = sel_q;
          state_d       = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          resp_d        = 2'b10;
          err_d         = 1'b1;
          start_write_d = 1'b0;
          start_read_d  = 1'b0;
          done0_d       = !sel_q;
          done1_d       = sel_q;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_ISSUE && addr_hs) begin
            start_write_d = 1'b0;
            start_read_d  = 1'b0;
            state_d       = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The last pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;
      sel_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rdata_q       <= '0;
      resp_q        <= 2'b00;
      err_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      start_write_q <= start_write_d;
      start_read_q  <= start_read_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      rdata_q       <= rdata_d;
      resp_q        <= resp_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata_o     = rdata_q;
  assign resp_o      = resp_q;
  assign err_o       = err_q;
  assign start_write = start_write_q;
  assign start_read  = start_read_q;
  assign write_id    = ID_WIDTH'(sel_q);
  assign read_id     = ID_WIDTH'(sel_q);
  assign write_addr  = addr_q;
  assign read_addr   = addr_q;
  assign write_data  = wdata_q;
  assign write_len   = 8'd0;
  assign read_len    = 8'd0;
  assign write_size  = 3'b010;
  assign read_size   = 3'b010;
  assign write_burst = 2'b01;
  assign read_burst  = 2'b01;
  assign write_strb  = '1;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb/tb_axi_master_arbiter.sv - self-checking bench for axi_master_arbiter
// Vector table, hand-written corner sequences and randomized traffic against a transaction-level model.
module tb_axi_master_arbiter;

  logic        clk, reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata_o;
  logic [1:0]  resp_o;
  logic        err_o, start_write, start_read;
  logic [3:0]  write_id, read_id;
  logic [31:0] write_addr, write_data, read_addr;
  logic [7:0]  write_len, read_len;
  logic [2:0]  write_size, read_size;
  logic [1:0]  write_burst, read_burst;
  logic [3:0]  write_strb;
  logic        awvalid, awready, arvalid, arready;
  logic        bvalid, bready, rvalid, rready, rlast;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axi_master_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata_o(rdata_o), .resp_o(resp_o), .err_o(err_o),
    .start_write(start_write), .start_read(start_read),
    .write_id(write_id), .write_addr(write_addr), .write_data(write_data),
    .read_id(read_id), .read_addr(read_addr),
    .write_len(write_len), .read_len(read_len),
    .write_size(write_size), .read_size(read_size),
    .write_burst(write_burst), .read_burst(read_burst),
    .write_strb(write_strb),
    .awvalid(awvalid), .awready(awready), .arvalid(arvalid), .arready(arready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp), .rdata(rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Slave / master-side environment state.
  int          sl_phase, sl_cnt, aw_dly, rsp_dly;
  bit          sl_we, fast, no_resp, noise;
  logic [1:0]  rsp_code;
  logic [31:0] smem [16];
  logic [1:0]  gnt_seen;
  int          dcnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_resp();
    if (sl_we) begin
      bvalid = 1'b1; bresp = rsp_code;
    end else begin
      rvalid = 1'b1; rlast = 1'b1; rresp = rsp_code; rdata = smem[read_addr[5:2]];
    end
  endtask

  // Advance one clock, then let the environment react to the registered outputs.
  task automatic step();
    bit hs, rst_was;
    hs      = (awvalid && awready) || (arvalid && arready);
    rst_was = reset;
    @(posedge clk); #1;
    cyc++;
    gnt_seen = gnt_seen | {gnt1, gnt0};
    dcnt     = dcnt + int'(done0) + int'(done1);
    awready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
    bresp = 0; rresp = 0; rdata = '0; bready = 1; rready = 1;
    awvalid = start_write; arvalid = start_read;
    if (hs && sl_we && !rst_was) smem[write_addr[5:2]] = write_data;
    if (rst_was || done0 || done1) sl_phase = 0;
    else begin
      if (hs) begin sl_phase = 2; sl_cnt = 0; end
      if (sl_phase == 0 && (start_write || start_read)) begin
        sl_phase = 1; sl_cnt = 0; sl_we = start_write;
      end
      if (sl_phase == 1) begin
        if (sl_cnt >= aw_dly) begin
          if (sl_we) awready = 1; else arready = 1;
          if (fast && !no_resp) drive_resp();
        end else sl_cnt++;
      end else if (sl_phase == 2 && !no_resp) begin
        if (sl_cnt >= rsp_dly) drive_resp(); else sl_cnt++;
      end
      if (noise && sl_phase == 2) begin
        if (sl_we) begin
          rvalid = 1'($urandom); rlast = 1'($urandom); rresp = 2'($urandom); rdata = $urandom;
        end else begin
          bvalid = 1'($urandom); bresp = 2'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1; req0 = 0; req1 = 0;
    step(); step();
    reset = 0;
  endtask

  // One request episode: present requests, check the issued transaction and its completion.
  task automatic txn(input bit r0, input bit r1, input bit w0, input bit w1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input bit ew, input bit ee, input logic [1:0] er,
                     input bit crd, input logic [31:0] erd, input string nm);
    int n;
    bit xw;
    logic [31:0] xa, xd;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    gnt_seen = 0; dcnt = 0;
    xw = ew ? w1 : w0; xa = ew ? a1 : a0; xd = ew ? d1 : d0;
    n = 0;
    while (!(gnt0 || gnt1) && n < 20) begin step(); n++; end
    chk({nm, "_gnt"}, {gnt1, gnt0}, ew ? 2'b10 : 2'b01);
    chk({nm, "_start"}, {start_write, start_read}, xw ? 2'b10 : 2'b01);
    if (xw) chk({nm, "_waddr"}, {write_id, write_addr, write_data}, {4'(ew), xa, xd});
    else    chk({nm, "_raddr"}, {read_id, read_addr}, {4'(ew), xa});
    n = 0;
    while (!(done0 || done1) && n < 100) begin step(); n++; end
    chk({nm, "_done"}, {done1, done0}, ew ? 2'b10 : 2'b01);
    chk({nm, "_resp"}, {err_o, resp_o}, {ee, er});
    if (crd) chk({nm, "_rdata"}, rdata_o, erd);
    req0 = 0; req1 = 0;
    step();
    chk({nm, "_after"}, {gnt1, gnt0, done1, done0, start_write, start_read}, 6'b0);
    chk({nm, "_once"}, {30'(dcnt), gnt_seen}, {30'd1, ew ? 2'b10 : 2'b01});
  endtask

  typedef struct {
    bit r0; bit r1; bit w0; bit w1;
    logic [31:0] a0; logic [31:0] a1; logic [31:0] d0; logic [31:0] d1;
    int aw_dly; int rsp_dly; logic [1:0] rsp;
    bit ew; bit ee; logic [1:0] er; bit crd; logic [31:0] erd;
  } vec_t;

  vec_t        vt [8];
  int          n, t0, ts, k, prev;
  bit          wk [4];
  int          tk [4];
  logic [31:0] mmem [16];
  bit          m_last, rr0, rr1, rw0, rw1, xew, xee, xcrd, xwe;
  logic [31:0] ra0, ra1, rd0, rd1, xerd, xa, xd;
  logic [1:0]  xer;
  int          pick;

  initial begin
    vt[0] = '{1,0,1,0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 1,2, 2'b00, 0,0,2'b00, 0,32'h0};
    vt[1] = '{0,1,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0, 2'b00, 1,0,2'b00, 1,32'hDEADBEEF};
    vt[2] = '{1,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 2,1, 2'b10, 0,1,2'b10, 1,32'hDEADBEEF};
    vt[3] = '{1,1,1,1, 32'h4, 32'h8, 32'h12345678, 32'hCAFEF00D, 0,3, 2'b01, 1,1,2'b01, 0,32'h0};
    vt[4] = '{0,1,0,0, 32'h0, 32'h8, 32'h0, 32'h0, 3,0, 2'b00, 1,0,2'b00, 1,32'hCAFEF00D};
    vt[5] = '{1,0,1,0, 32'hC, 32'h0, 32'hA5, 32'h0, 0,0, 2'b11, 0,1,2'b11, 0,32'h0};
    vt[6] = '{1,1,0,0, 32'hC, 32'h0, 32'h0, 32'h0, 1,1, 2'b00, 1,0,2'b00, 1,32'hDEADBEEF};
    vt[7] = '{1,1,0,0, 32'hC, 32'h0, 32'h0, 32'h0, 0,2, 2'b00, 0,0,2'b00, 1,32'hA5};

    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    awvalid = 0; awready = 0; arvalid = 0; arready = 0; bvalid = 0; bready = 1; bresp = 0;
    rvalid = 0; rready = 1; rlast = 0; rresp = 0; rdata = 0;
    sl_phase = 0; sl_cnt = 0; sl_we = 0; aw_dly = 0; rsp_dly = 0;
    fast = 0; no_resp = 0; noise = 1; rsp_code = 0; gnt_seen = 0; dcnt = 0;
    for (int i = 0; i < 16; i++) smem[i] = 32'h5A00_0000 + 32'(i);

    // Reset state
    reset = 1;
    step(); step();
    chk("rst_ctrl", {gnt0, gnt1, done0, done1, start_write, start_read, err_o, resp_o}, 0);
    chk("rst_data", {rdata_o, write_addr, write_data, read_addr, write_id, read_id}, 0);
    chk("rst_const", {write_len, read_len, write_size, read_size, write_burst, read_burst, write_strb},
        {8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 4'hF});
    reset = 0;
    step();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      aw_dly = vt[i].aw_dly; rsp_dly = vt[i].rsp_dly; rsp_code = vt[i].rsp;
      txn(vt[i].r0, vt[i].r1, vt[i].w0, vt[i].w1, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1,
          vt[i].ew, vt[i].ee, vt[i].er, vt[i].crd, vt[i].erd, $sformatf("vec%0d", i));
    end
    chk("const_hold", {write_len, read_len, write_size, read_size, write_burst, read_burst, write_strb},
        {8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 4'hF});

    // Timeout: address accepted, write response never arrives
    no_resp = 1; aw_dly = 2; rsp_dly = 0; rsp_code = 0;
    req0 = 1; we0 = 1; addr0 = 32'h14; wdata0 = 32'h0BAD_F00D;
    n = 0;
    while (!gnt0 && n < 20) begin step(); n++; end
    t0 = cyc; ts = -1;
    n = 0;
    while (!(done0 || done1) && n < 40) begin
      step(); n++;
      if (ts < 0 && !start_write) ts = cyc;
    end
    chk("to_start_drop", 64'(ts - t0), 64'd3);
    chk("to_latency", 64'(cyc - t0), 64'd16);
    chk("to_resp", {done1, done0, err_o, resp_o}, {2'b01, 1'b1, 2'b10});
    req0 = 0;
    step();
    no_resp = 0;
    txn(0, 1, 0, 0, 32'h0, 32'h14, 32'h0, 32'h0, 1, 0, 2'b00, 1, 32'h0BAD_F00D, "after_to");

    // Reset while waiting for a read response
    do_reset();
    no_resp = 1; aw_dly = 0;
    req0 = 1; we0 = 0; addr0 = 32'h8;
    n = 0;
    while (!gnt0 && n < 20) begin step(); n++; end
    step(); step(); step();
    reset = 1; req0 = 0;
    step();
    chk("rstw_clear", {start_write, start_read, gnt1, gnt0, done1, done0}, 6'b0);
    reset = 0; dcnt = 0;
    for (int i = 0; i < 20; i++) step();
    chk("rstw_no_done", 64'(dcnt), 64'd0);
    no_resp = 0;
    txn(1, 1, 0, 0, 32'h8, 32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 1, 32'hCAFEF00D, "rstw_tie");

    // Round-robin with both requests held; completion coincides with the address handshake
    do_reset();
    fast = 1; aw_dly = 0; rsp_code = 0;
    req0 = 1; req1 = 1; we0 = 1; we1 = 0; addr0 = 32'h20; addr1 = 32'h24; wdata0 = 32'h77;
    k = 0; n = 0; prev = 0;
    while (k < 4 && n < 60) begin
      step(); n++;
      if ((gnt0 || gnt1) && prev == 0) begin wk[k] = gnt1; tk[k] = cyc; k++; end
      prev = int'(gnt0 || gnt1);
    end
    chk("rr_order", {wk[0], wk[1], wk[2], wk[3]}, 4'b0101);
    for (int i = 1; i < 4; i++) chk($sformatf("rr_space%0d", i), 64'(tk[i] - tk[i-1]), 64'd3);
    req0 = 0; req1 = 0;
    step(); step(); step();

    // Randomized traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom;
      mmem[i] = smem[i];
    end
    m_last = 1;
    for (int t = 0; t < 40; t++) begin
      pick = $urandom_range(0, 2);
      rr0 = (pick != 1); rr1 = (pick != 0);
      rw0 = 1'($urandom); rw1 = 1'($urandom);
      ra0 = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
      ra1 = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
      rd0 = $urandom; rd1 = $urandom;
      aw_dly = $urandom_range(0, 3); rsp_dly = $urandom_range(0, 3);
      fast = ($urandom_range(0, 3) == 0); no_resp = ($urandom_range(0, 7) == 0);
      rsp_code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      // Winner: the only requester, or on a tie the one not served last time.
      xew = (rr0 && rr1) ? !m_last : rr1;
      m_last = xew;
      xwe = xew ? rw1 : rw0; xa = xew ? ra1 : ra0; xd = xew ? rd1 : rd0;
      xcrd = 0; xerd = 0;
      if (xwe) mmem[xa[5:2]] = xd;
      else begin xcrd = !no_resp; xerd = mmem[xa[5:2]]; end
      xee = no_resp ? 1'b1 : (rsp_code != 2'b00);
      xer = no_resp ? 2'b10 : rsp_code;
      txn(rr0, rr1, rw0, rw1, ra0, ra1, rd0, rd1, xew, xee, xer, xcrd, xerd, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
